// File: rtl/psa_pkg.sv
// Shared types and constants for the sequential packed 4x4-bit saturating subtractor.
// Optional feature macro used by the top: PSA_SUB_NIB_FLAGS_EN (per-nibble overflow flags).
package psa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } psa_state_e;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int CNT_W   = 2;

    localparam logic [NIB_W-1:0] SAT_POS  = 4'h7;
    localparam logic [NIB_W-1:0] SAT_NEG  = 4'h8;
    localparam logic [CNT_W-1:0] LAST_NIB = 2'd3;

endpackage

// File: rtl/sat_sub_4bit.sv
// Combinational signed 4-bit subtractor with saturation; time-shared by psa_16bit_sub_seq.
module sat_sub_4bit
    import psa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] diff,
    output logic             pos_ovfl,
    output logic             neg_ovfl
);

    logic [NIB_W-1:0] w_raw;

    assign w_raw    = a - b;
    // Overflow only possible when operand signs differ and the result sign follows b.
    assign pos_ovfl = ~a[NIB_W-1] &  b[NIB_W-1] &  w_raw[NIB_W-1];
    assign neg_ovfl =  a[NIB_W-1] & ~b[NIB_W-1] & ~w_raw[NIB_W-1];

    // Saturation select
    always_comb begin
        diff = w_raw;
        if (pos_ovfl) begin
            diff = SAT_POS;
        end else if (neg_ovfl) begin
            diff = SAT_NEG;
        end else begin
            diff = w_raw;
        end
    end

endmodule

// File: rtl/psa_16bit_sub_seq.sv
// Sequential 16-bit packed saturating subtractor: one nibble per CALC cycle, LSN first.
// Define PSA_SUB_NIB_FLAGS_EN to add the per-nibble overflow output ovfl_nib.
module psa_16bit_sub_seq
    import psa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Diff,
    output logic        Error
`ifdef PSA_SUB_NIB_FLAGS_EN
    ,
    output logic [3:0]  ovfl_nib
`endif
);

    psa_state_e       r_state;
    psa_state_e       w_state_nxt;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [15:0]      r_diff;
    logic             r_error;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_accept;
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_nib_diff;
    logic             w_pos_ovfl;
    logic             w_neg_ovfl;

    assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_a_nib  = r_a[{r_cnt, 2'b00} +: NIB_W];
    assign w_b_nib  = r_b[{r_cnt, 2'b00} +: NIB_W];

    sat_sub_4bit u_sat_sub (
        .a        (w_a_nib),
        .b        (w_b_nib),
        .diff     (w_nib_diff),
        .pos_ovfl (w_pos_ovfl),
        .neg_ovfl (w_neg_ovfl)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == LAST_NIB) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs follow the state being entered so they are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Operand capture and per-nibble result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_diff  <= 16'h0000;
            r_error <= 1'b0;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_error <= 1'b0;
                        r_cnt   <= 2'd0;
                    end
                end
                CALC: begin
                    r_diff[{r_cnt, 2'b00} +: NIB_W] <= w_nib_diff;
                    r_error <= r_error | w_pos_ovfl | w_neg_ovfl;
                    r_cnt   <= r_cnt + 2'd1;
                end
                DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

`ifdef PSA_SUB_NIB_FLAGS_EN
    logic [NUM_NIB-1:0] r_ovfl_nib;

    // Per-nibble overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfl_nib <= 4'h0;
        end else if (w_accept) begin
            r_ovfl_nib <= 4'h0;
        end else if (r_state == CALC) begin
            r_ovfl_nib[r_cnt] <= w_pos_ovfl | w_neg_ovfl;
        end else begin
            r_ovfl_nib <= r_ovfl_nib;
        end
    end

    assign ovfl_nib = r_ovfl_nib;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Diff      = r_diff;
    assign Error     = r_error;

endmodule

// File: tb/tb_psa_16bit_sub_seq.sv
// Self-checking bench for psa_16bit_sub_seq: directed vector table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_psa_16bit_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Error;
`ifdef PSA_SUB_NIB_FLAGS_EN
    logic [3:0]  ovfl_nib;
`endif

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int exp_ops  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        e;
        logic [3:0]  n;
    } vec_t;

    vec_t tbl [6];

    psa_16bit_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Error     (Error)
`ifdef PSA_SUB_NIB_FLAGS_EN
        ,
        .ovfl_nib  (ovfl_nib)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of completed output handshakes
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: signed nibble arithmetic with clamping to [-8, 7]
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic e, output logic [3:0] n);
        int sa, sb, r;
        logic [31:0] rv;
        d = 16'h0000;
        n = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sa = int'(a[4*i +: 4]);
            sb = int'(b[4*i +: 4]);
            if (sa > 7) sa = sa - 16;
            if (sb > 7) sb = sb - 16;
            r = sa - sb;
            if (r > 7) begin
                d[4*i +: 4] = 4'h7;
                n[i] = 1'b1;
            end else if (r < -8) begin
                d[4*i +: 4] = 4'h8;
                n[i] = 1'b1;
            end else begin
                rv = 32'(r);
                d[4*i +: 4] = rv[3:0];
            end
        end
        e = |n;
    endfunction

    task automatic check_result(input string nm, input logic [15:0] d, input logic e, input logic [3:0] n);
        chk({nm, "_diff"}, 32'(Diff), 32'(d));
        chk({nm, "_err"}, 32'(Error), 32'(e));
`ifdef PSA_SUB_NIB_FLAGS_EN
        chk({nm, "_nib"}, 32'(ovfl_nib), 32'(n));
`endif
    endtask

    // Runs one operation from a negedge with in_ready high; returns at a negedge after the handshake.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                         input bit toggle, input string nm, output longint acc_t);
        int guard;
        int lat;
        logic [15:0] d;
        logic e;
        logic [3:0] n;
        ref_sub(a, b, d, e, n);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = (stall == 0);
        @(posedge clk);
        acc_t = longint'($time);
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            A = 16'($urandom);
            B = 16'($urandom);
        end
        chk({nm, "_latency"}, 32'(lat), 32'd4);
        check_result(nm, d, e, n);
        for (int k = 0; k < stall; k++) begin
            if (toggle) begin
                in_valid = 1'($urandom);
                A = 16'($urandom);
                B = 16'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_hold_inrdy"}, 32'(in_ready), 32'd0);
            check_result({nm, "_hold"}, d, e, n);
        end
        out_ready = 1'b1;
        in_valid  = toggle;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({nm, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_post_inrdy"}, 32'(in_ready), 32'd1);
        exp_ops++;
    endtask

    initial begin
        longint t_acc;
        longint t_prev;
        int stall;
        logic [15:0] ra, rb;

        tbl[0] = '{a: 16'h1234, b: 16'h1111, d: 16'h0123, e: 1'b0, n: 4'h0};
        tbl[1] = '{a: 16'h7777, b: 16'h8888, d: 16'h7777, e: 1'b1, n: 4'hF};
        tbl[2] = '{a: 16'h7380, b: 16'hF112, d: 16'h728E, e: 1'b1, n: 4'b1010};
        tbl[3] = '{a: 16'h8888, b: 16'h1111, d: 16'h8888, e: 1'b1, n: 4'hF};
        tbl[4] = '{a: 16'h0000, b: 16'h0000, d: 16'h0000, e: 1'b0, n: 4'h0};
        tbl[5] = '{a: 16'hFFFF, b: 16'h0001, d: 16'hFFFE, e: 1'b0, n: 4'h0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 16'h0; B = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
`ifdef PSA_SUB_NIB_FLAGS_EN
        chk("rst_nib", 32'(ovfl_nib), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, back-to-back with out_ready high: also checks 6-cycle throughput
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, 0, 1'b0, $sformatf("vec%0d", i), t_acc);
            chk($sformatf("vec%0d_expected_table", i), 32'(tbl[i].d), 32'(tbl[i].d));
            if (i > 0) chk($sformatf("vec%0d_throughput", i), 32'(t_acc - t_prev), 32'd60);
            t_prev = t_acc;
        end

        // Long consumer stall with a toggling late request
        do_op(16'h5A3C, 16'hC3A5, 10, 1'b1, "stall", t_acc);
        repeat (3) begin
            @(negedge clk);
            chk("stall_late_req_ignored", 32'(out_valid), 32'd0);
        end

        // Reset during CALC with cnt=2
        in_valid = 1'b1; A = 16'h1234; B = 16'h1111; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(Diff), 32'd0);
        chk("midrst_error", 32'(Error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
            chk("midrst_idle_ready", 32'(in_ready), 32'd1);
        end
        out_ready = 1'b0;
        do_op(16'h8888, 16'h1111, 0, 1'b0, "after_rst", t_acc);

        // Randomized operations with occasional consumer stalls
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(ra, rb, stall, 1'b0, "rnd", t_acc);
        end

        @(negedge clk);
        chk("handshake_count", 32'(hs_cnt), 32'(exp_ops));
        chk("random_op_count", 32'(exp_ops), 32'd10008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
